// File: rtl/arb_pkg.sv
// Shared state encoding and sizing for the four-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decoder24en.sv
// 2-to-4 one-hot decoder with active-low enable; all outputs low when disabled.
module decoder24en (
  input  logic [1:0] binary,
  input  logic       en_L,
  output logic [3:0] dec
);

  always_comb begin
    dec = '0;
    if (!en_L) dec[binary] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter; a grant is held until done or request withdrawal.
// Define ARB_TIMEOUT_EN to bound each grant to HOLD_MAX cycles with a timeout pulse.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter logic [3:0] HOLD_MAX = 4'd15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_id,
  output logic               busy,
  output logic               timeout
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             rel_norm;
  logic             release_ev;

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = HOLD_MAX - 4'd1;

  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
  logic       tmo_hit;

  assign tmo_hit    = (state_q == GRANT) && (hold_cnt_q == HOLD_LAST);
  assign release_ev = rel_norm | tmo_hit;
`else
  assign release_ev = rel_norm;
`endif

  assign rel_norm = done | ~req[grant_id_q];

  // Search starts just after the last holder, so the holder itself is tried last.
  always_comb begin : rr_search
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last_q + IDX_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = '0;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          grant_id_d = win_idx;
          last_d     = win_idx;
        end
      end
      GRANT: begin
        if (release_ev) begin
          if (win_found) begin
            grant_id_d = win_idx;
            last_d     = win_idx;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = release_ev ? 4'd0 : hold_cnt_q + 4'd1;
        // A forced release only signals when nothing released normally.
        timeout_d  = tmo_hit & ~rel_norm;
`endif
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      grant_id_q <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  // The hold limit has no effect here; timeout stays constant low.
  assign timeout = 1'b0 & (HOLD_MAX != 4'd0);
`endif

  decoder24en u_grant_dec (
    .binary (grant_id_q),
    .en_L   (~busy),
    .dec    (grant)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: vector table, corner sequences and a
// randomized run against a behavioural round-robin model.
module tb_rr_arbiter4;

  localparam logic [3:0] HOLD = 4'd4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: holder index (-1 = none), last holder, cycles held, pulse.
  int m_holder;
  int m_last;
  int m_cnt;
  bit m_tmo;

  rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_last   = 3;
    m_cnt    = 0;
    m_tmo    = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic d);
    bit normal;
    bit forced;
    int w;
    m_tmo = 1'b0;
    w = pick(r, m_last);
    if (m_holder < 0) begin
      if (w >= 0) begin
        m_holder = w;
        m_last   = w;
        m_cnt    = 0;
      end
    end else begin
      normal = d || !r[m_holder];
      forced = TMO_EN && (m_cnt == int'(HOLD) - 1);
      if (normal || forced) begin
        m_tmo = forced && !normal;
        if (w >= 0) begin
          m_holder = w;
          m_last   = w;
        end else begin
          m_holder = -1;
        end
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [3:0] eg;
    eg = (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
    check({tag, " grant"}, 32'(grant), 32'(eg));
    check({tag, " busy"}, 32'(busy), 32'(m_holder >= 0));
    if (m_holder >= 0) check({tag, " grant_id"}, 32'(grant_id), 32'(m_holder));
    check({tag, " timeout"}, 32'(timeout), 32'(m_tmo));
  endtask

  // One clock edge; inputs captured before the edge feed the model.
  task automatic tick(input string tag);
    logic [3:0] r;
    logic       d;
    r = req;
    d = done;
    @(posedge clock);
    #1;
    model_edge(r, d);
    compare_model(tag);
  endtask

  // Called just after a sampling point; reset pulses between edges.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       busy;
  } vec_t;

  vec_t       tbl[13];
  logic [3:0] rr_seq[9];

  initial begin
    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b1};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1};
    tbl[2]  = '{4'b0110, 1'b1, 4'b0010, 1'b1};
    tbl[3]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};
    tbl[4]  = '{4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[5]  = '{4'b1000, 1'b0, 4'b1000, 1'b1};
    tbl[6]  = '{4'b1000, 1'b1, 4'b1000, 1'b1};
    tbl[7]  = '{4'b1000, 1'b0, 4'b1000, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[10] = '{4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[11] = '{4'b1111, 1'b0, 4'b0010, 1'b1};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    rr_seq  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                4'b0100, 4'b1000, 4'b1000, 4'b0001};

    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    #12;
    check("reset grant", 32'(grant), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset grant_id", 32'(grant_id), 32'h0);
    check("reset timeout", 32'(timeout), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Table vectors, one clock edge each, continuing from reset.
    for (int i = 0; i < 13; i++) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_grant", i), 32'(grant), 32'(tbl[i].grant));
      check($sformatf("vec%0d tbl_busy", i), 32'(busy), 32'(tbl[i].busy));
    end

    // All requesting, done every second cycle: strict rotation, no idle gaps.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      done = (i > 0) && (i % 2 == 0);
      tick($sformatf("rot%0d", i));
      check($sformatf("rot%0d seq_grant", i), 32'(grant), 32'(rr_seq[i]));
      check($sformatf("rot%0d seq_busy", i), 32'(busy), 32'h1);
    end

    // Asynchronous reset mid-grant drops the grant before the next edge.
    do_reset();
    req  = 4'b0100;
    done = 1'b0;
    tick("mid0");
    tick("mid1");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst grant", 32'(grant), 32'h0);
    check("async_rst busy", 32'(busy), 32'h0);
    check("async_rst timeout", 32'(timeout), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    req   = 4'b1010;
    tick("post_rst");
    check("post_rst lowest", 32'(grant), 32'h2);

`ifdef ARB_TIMEOUT_EN
    // Holder 0 never releases: forced handover after HOLD grant cycles.
    do_reset();
    req  = 4'b0011;
    done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick($sformatf("tmo%0d", i));
      check($sformatf("tmo%0d exp_grant", i), 32'(grant), (i < 4) ? 32'h1 : 32'h2);
      check($sformatf("tmo%0d exp_pulse", i), 32'(timeout), 32'(i == 4));
    end

    // done on the limit cycle is a normal release: no pulse.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 4; i++) tick($sformatf("sup%0d", i));
    done = 1'b1;
    tick("sup_rel");
    check("sup_rel grant", 32'(grant), 32'h2);
    check("sup_rel pulse", 32'(timeout), 32'h0);
`endif

    // Randomized traffic with occasional mid-cycle resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_model($sformatf("rnd%0d rst", i));
        @(negedge clock);
        reset = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      tick($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
